// File: rtl/simmem_release_scheduler.sv
// simmem_release_scheduler: per-ID delayed release slots driving the response bank release_en vector
module simmem_release_scheduler #(
    parameter int unsigned IDWidth    = 8,
    parameter int unsigned NumSlots   = 16,
    parameter int unsigned DelayWidth = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [IDWidth-1:0]          in_id_i,
    input  logic [DelayWidth-1:0]       in_delay_i,
    output logic [2**IDWidth-1:0]       release_en_o,
    input  logic                        released_valid_i,
    input  logic [IDWidth-1:0]          released_id_i,
    output logic [$clog2(NumSlots):0]   slots_used_o
);
    localparam int unsigned SlotW = $clog2(NumSlots);
    localparam int unsigned UsedW = SlotW + 1;

    typedef enum logic [1:0] {Free, Counting, Expired} slot_state_e;

    slot_state_e             state_q [NumSlots];
    slot_state_e             state_d [NumSlots];
    logic [IDWidth-1:0]      id_q    [NumSlots];
    logic [IDWidth-1:0]      id_d    [NumSlots];
    logic [DelayWidth-1:0]   cnt_q   [NumSlots];
    logic [DelayWidth-1:0]   cnt_d   [NumSlots];
    logic [SlotW-1:0]        alloc_idx, free_idx;
    logic                    any_free, free_hit, alloc, do_free;

    // Lowest-index FREE slot for allocation and lowest-index matching EXPIRED slot for release
    always_comb begin
        alloc_idx = '0;
        free_idx  = '0;
        any_free  = 1'b0;
        free_hit  = 1'b0;
        for (int s = NumSlots - 1; s >= 0; s--) begin
            if (state_q[s] == Free) begin
                any_free  = 1'b1;
                alloc_idx = SlotW'(s);
            end
            if (state_q[s] == Expired && id_q[s] == released_id_i) begin
                free_hit = 1'b1;
                free_idx = SlotW'(s);
            end
        end
    end

    assign in_ready_o = any_free;
    assign alloc      = in_valid_i & any_free;
    assign do_free    = released_valid_i & free_hit;

    // Per-slot next state: allocation loads, release frees, counting slots tick down to expiry
    always_comb begin
        for (int s = 0; s < NumSlots; s++) begin
            state_d[s] = state_q[s];
            id_d[s]    = id_q[s];
            cnt_d[s]   = cnt_q[s];
            if (alloc && alloc_idx == SlotW'(s)) begin
                state_d[s] = (in_delay_i == '0) ? Expired : Counting;
                id_d[s]    = in_id_i;
                cnt_d[s]   = in_delay_i;
            end else if (do_free && free_idx == SlotW'(s)) begin
                state_d[s] = Free;
            end else if (state_q[s] == Counting) begin
                state_d[s] = (cnt_q[s] == DelayWidth'(1)) ? Expired : Counting;
                cnt_d[s]   = (cnt_q[s] == DelayWidth'(1)) ? cnt_q[s] : cnt_q[s] - DelayWidth'(1);
            end
        end
    end

    // Slot registers; reset discards every slot at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumSlots; s++) begin
                state_q[s] <= Free;
                id_q[s]    <= '0;
                cnt_q[s]   <= '0;
            end
        end else begin
            for (int s = 0; s < NumSlots; s++) begin
                state_q[s] <= state_d[s];
                id_q[s]    <= id_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
        end
    end

    // Release vector and occupancy derived from registered slot state only
    always_comb begin
        release_en_o = '0;
        slots_used_o = '0;
        for (int s = 0; s < NumSlots; s++) begin
            if (state_q[s] == Expired) release_en_o[id_q[s]] = 1'b1;
            if (state_q[s] != Free) slots_used_o = slots_used_o + UsedW'(1);
        end
    end

    // A release for an ID with no expired slot is a bank protocol violation; it is dropped
    always_ff @(posedge clk_i) begin
        if (rst_ni && released_valid_i)
            assert (free_hit) else $warning("release for id %0d with no expired slot", released_id_i);
    end
endmodule

// File: tb/tb_simmem_release_scheduler.sv
// tb_simmem_release_scheduler: directed checks of allocation, countdown, release and reset
module tb_simmem_release_scheduler;
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [7:0]   in_id_i = '0;
    logic [7:0]   in_delay_i = '0;
    logic [255:0] release_en_o;
    logic         released_valid_i = 1'b0;
    logic [7:0]   released_id_i = '0;
    logic [4:0]   slots_used_o;
    int           errors = 0;
    int           checks = 0;
    int           n;

    simmem_release_scheduler dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_id_i(in_id_i), .in_delay_i(in_delay_i),
        .release_en_o(release_en_o),
        .released_valid_i(released_valid_i), .released_id_i(released_id_i),
        .slots_used_o(slots_used_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] bit_at(input int i);
        logic [255:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic req(input logic [7:0] id, input logic [7:0] d);
        in_valid_i = 1'b1;
        in_id_i    = id;
        in_delay_i = d;
    endtask

    task automatic rel(input logic [7:0] id);
        released_valid_i = 1'b1;
        released_id_i    = id;
    endtask

    task automatic idle();
        in_valid_i       = 1'b0;
        released_valid_i = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_ready", in_ready_o, 1);
        chk("reset_release", release_en_o, 0);
        chk("reset_used", slots_used_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        // single request: id 3, delay 5
        req(3, 5);
        tick();
        idle();
        chk("single_used1", slots_used_o, 1);
        repeat (4) tick();
        chk("single_early", release_en_o, 0);
        tick();
        chk("single_rise", release_en_o, bit_at(3));
        tick();
        chk("single_hold", release_en_o, bit_at(3));
        rel(3);
        tick();
        idle();
        chk("single_fall", release_en_o, 0);
        chk("single_used0", slots_used_o, 0);

        // zero delay
        req(0, 0);
        tick();
        idle();
        chk("zero_rise", release_en_o, bit_at(0));
        rel(0);
        tick();
        idle();
        chk("zero_fall", release_en_o, 0);

        // same ID, two entries
        req(7, 2);
        tick();
        tick();
        idle();
        chk("same_early", release_en_o, 0);
        tick();
        chk("same_rise", release_en_o, bit_at(7));
        chk("same_used2", slots_used_o, 2);
        rel(7);
        tick();
        idle();
        chk("same_hold", release_en_o, bit_at(7));
        chk("same_used1", slots_used_o, 1);
        rel(7);
        tick();
        idle();
        chk("same_clear", release_en_o, 0);
        chk("same_used0", slots_used_o, 0);

        // concurrent free of id 1 and allocation of id 2
        req(1, 0);
        tick();
        idle();
        chk("conc_setup", release_en_o, bit_at(1));
        req(2, 0);
        rel(1);
        tick();
        idle();
        chk("conc_used", slots_used_o, 1);
        chk("conc_release", release_en_o, bit_at(2));
        rel(2);
        tick();
        idle();
        chk("conc_empty", slots_used_o, 0);

        // bogus free: nothing expired for id 9
        req(4, 0);
        tick();
        idle();
        rel(9);
        tick();
        idle();
        chk("bogus_used", slots_used_o, 1);
        chk("bogus_release", release_en_o, bit_at(4));
        rel(4);
        tick();
        idle();
        chk("bogus_cleanup", slots_used_o, 0);

        // full: 16 requests with delay 255, ids 32..47
        for (int k = 0; k < 16; k++) begin
            req(8'(32 + k), 255);
            tick();
        end
        idle();
        chk("full_ready", in_ready_o, 0);
        chk("full_used", slots_used_o, 16);
        req(100, 0);
        tick();
        idle();
        chk("full_ignored_used", slots_used_o, 16);
        chk("full_ignored_rel", release_en_o, 0);
        n = 0;
        while (release_en_o[32] !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("full_expiry_time", n, 239);
        chk("full_first_only", release_en_o, bit_at(32));
        chk("full_ready_still0", in_ready_o, 0);
        rel(32);
        tick();
        idle();
        chk("full_ready_back", in_ready_o, 1);
        chk("full_used15", slots_used_o, 15);

        // asynchronous reset with 5 busy slots
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            req(8'(10 + k), 50);
            tick();
        end
        idle();
        chk("areset_busy", slots_used_o, 5);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("areset_used", slots_used_o, 0);
        chk("areset_ready", in_ready_o, 1);
        chk("areset_release", release_en_o, 0);
        tick();
        rst_ni = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
